// File: rtl/apb_requester_arbiter.sv
// Round-robin arbiter that shares one APB completer between N_REQ clients and runs one transfer per grant.
// Optional ACCESS wait-state timeout is enabled by defining APB_ARB_TIMEOUT_EN.
module apb_requester_arbiter #(
  parameter int N_REQ       = 4,
  parameter int ADDR_W      = 5,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                     pclk,
  input  logic                     prst_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         req_write,
  input  logic [N_REQ*ADDR_W-1:0]  req_addr,
  input  logic [N_REQ*DATA_W-1:0]  req_wdata,
  output logic [N_REQ-1:0]         req_gnt,
  output logic [N_REQ-1:0]         rsp_valid,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic                     rsp_err,
  output logic [ADDR_W-1:0]        paddr,
  output logic                     pselx,
  output logic                     penable,
  output logic                     pwrite,
  output logic [DATA_W-1:0]        pwdata,
  input  logic                     pready,
  input  logic [DATA_W-1:0]        prdata
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

  logic [1:0]       state;
  logic [PTR_W-1:0] rr_ptr, win, nxt_win, scan_idx;
  logic             found;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] wait_cnt;
  logic             err_q;
  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

  // Scan starts one past the last winner and wraps, so every client is served within N_REQ grants.
  always_comb begin
    found    = 1'b0;
    nxt_win  = rr_ptr;
    scan_idx = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      scan_idx = PTR_W'((int'(rr_ptr) + k) % N_REQ);
      if (!found && req[scan_idx]) begin
        found   = 1'b1;
        nxt_win = scan_idx;
      end
    end
  end

  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      state     <= S_IDLE;
      rr_ptr    <= PTR_W'(N_REQ - 1);
      win       <= '0;
      req_gnt   <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      paddr     <= '0;
      pselx     <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      pwdata    <= '0;
`ifdef APB_ARB_TIMEOUT_EN
      wait_cnt  <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      req_gnt   <= '0;
      rsp_valid <= '0;
      case (state)
        S_IDLE: begin
          if (found) begin
            state   <= S_SETUP;
            win     <= nxt_win;
            rr_ptr  <= nxt_win;
            paddr   <= req_addr[nxt_win*ADDR_W +: ADDR_W];
            pwrite  <= req_write[nxt_win];
            pwdata  <= req_wdata[nxt_win*DATA_W +: DATA_W];
            req_gnt <= ONE_HOT0 << nxt_win;
            pselx   <= 1'b1;
            penable <= 1'b0;
          end
        end
        S_SETUP: begin
          state   <= S_ACCESS;
          penable <= 1'b1;
`ifdef APB_ARB_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        S_ACCESS: begin
          if (pready) begin
            state     <= S_IDLE;
            pselx     <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= ONE_HOT0 << win;
            rsp_rdata <= pwrite ? '0 : prdata;
`ifdef APB_ARB_TIMEOUT_EN
            err_q     <= 1'b0;
          end else if (wait_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            // This edge is the TIMEOUT_CYC-th unanswered ACCESS cycle: abort and report.
            state     <= S_IDLE;
            pselx     <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= ONE_HOT0 << win;
            rsp_rdata <= '0;
            err_q     <= 1'b1;
          end else begin
            wait_cnt  <= wait_cnt + 1'b1;
`endif
          end
        end
        default: begin
          state   <= S_IDLE;
          pselx   <= 1'b0;
          penable <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_requester_arbiter.sv
// Directed bench for apb_requester_arbiter (N_REQ=4, ADDR_W=5, DATA_W=32, TIMEOUT_CYC=16).
module tb_apb_requester_arbiter;

  localparam int N  = 4;
  localparam int AW = 5;
  localparam int DW = 32;

  logic            pclk = 1'b0;
  logic            prst_n;
  logic [N-1:0]    req, req_write;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    req_gnt, rsp_valid;
  logic [DW-1:0]   rsp_rdata, pwdata, prdata;
  logic            rsp_err, pselx, penable, pwrite, pready;
  logic [AW-1:0]   paddr;

  int errors = 0;
  int checks = 0;

  apb_requester_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(16)) dut (
    .pclk(pclk), .prst_n(prst_n), .req(req), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_gnt(req_gnt), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .paddr(paddr), .pselx(pselx), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .pready(pready), .prdata(prdata)
  );

  always #5 pclk = ~pclk;

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_out(input string tag);
    chk({tag, ".pselx"}, 64'(pselx), 64'd0);
    chk({tag, ".penable"}, 64'(penable), 64'd0);
    chk({tag, ".gnt"}, 64'(req_gnt), 64'd0);
    chk({tag, ".rsp_valid"}, 64'(rsp_valid), 64'd0);
  endtask

  initial begin
    prst_n = 1'b0; req = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    pready = 1'b1; prdata = '0;
    tick(); tick();
    chk_idle_out("rst");
    chk("rst.paddr", 64'(paddr), 64'd0);
    chk("rst.pwdata", 64'(pwdata), 64'd0);
    chk("rst.pwrite", 64'(pwrite), 64'd0);
    chk("rst.rdata", 64'(rsp_rdata), 64'd0);
    chk("rst.err", 64'(rsp_err), 64'd0);
    prst_n = 1'b1;
    tick();

    // Client 2 write, zero wait states.
    req[2] = 1'b1; req_write[2] = 1'b1; req_addr[2*AW +: AW] = 5'd5; req_wdata[2*DW +: DW] = 32'hDEADBEEF;
    tick();
    chk("w.gnt", 64'(req_gnt), 64'b0100);
    chk("w.psel", 64'(pselx), 64'd1);
    chk("w.pen_setup", 64'(penable), 64'd0);
    chk("w.paddr", 64'(paddr), 64'd5);
    chk("w.pwrite", 64'(pwrite), 64'd1);
    chk("w.pwdata", 64'(pwdata), 64'hDEADBEEF);
    req = '0;
    tick();
    chk("w.pen_access", 64'(penable), 64'd1);
    chk("w.gnt_off", 64'(req_gnt), 64'd0);
    chk("w.paddr_acc", 64'(paddr), 64'd5);
    tick();
    chk("w.rsp_valid", 64'(rsp_valid), 64'b0100);
    chk("w.rsp_err", 64'(rsp_err), 64'd0);
    chk("w.rdata0", 64'(rsp_rdata), 64'd0);
    chk("w.psel_off", 64'(pselx), 64'd0);
    chk("w.paddr_hold", 64'(paddr), 64'd5);
    tick();
    chk("w.rsp_pulse", 64'(rsp_valid), 64'd0);

    // Client 0 read with two wait states.
    req[0] = 1'b1; req_write[0] = 1'b0; req_addr[0 +: AW] = 5'd5; pready = 1'b0;
    tick();
    chk("r.gnt", 64'(req_gnt), 64'b0001);
    chk("r.pwrite", 64'(pwrite), 64'd0);
    req = '0;
    tick();
    chk("r.acc1", 64'(penable), 64'd1);
    tick();
    chk("r.acc2", 64'({pselx, penable}), 64'b11);
    chk("r.acc2_rsp", 64'(rsp_valid), 64'd0);
    tick();
    chk("r.acc3", 64'({pselx, penable}), 64'b11);
    pready = 1'b1; prdata = 32'hDEADBEEF;
    tick();
    chk("r.rsp_valid", 64'(rsp_valid), 64'b0001);
    chk("r.rdata", 64'(rsp_rdata), 64'hDEADBEEF);
    chk("r.err", 64'(rsp_err), 64'd0);

    // Reset so the all-request round starts from client 0.
    prst_n = 1'b0; #2; prst_n = 1'b1;
    tick();
    req = 4'b1111; req_write = '0;
    for (int k = 0; k < 5; k++) begin
      prdata = 32'hA5A5_0000 + 32'(k);
      tick();
      chk($sformatf("rr.gnt%0d", k), 64'(req_gnt), 64'(4'b0001 << (k % 4)));
      tick();
      chk($sformatf("rr.gap%0d", k), 64'(req_gnt), 64'd0);
      tick();
      chk($sformatf("rr.rsp%0d", k), 64'(rsp_valid), 64'(4'b0001 << (k % 4)));
      chk($sformatf("rr.rdat%0d", k), 64'(rsp_rdata), 64'(32'hA5A5_0000 + 32'(k)));
      chk($sformatf("rr.gnt_idle%0d", k), 64'(req_gnt), 64'd0);
    end
    req = '0;
    tick();

    // Bring rr_ptr to 1, then 1 and 3 compete: 3 first, then wrap to 1.
    req = 4'b0010;
    tick();
    chk("wrap.g1", 64'(req_gnt), 64'b0010);
    req = '0;
    tick(); tick();
    req = 4'b1010;
    tick();
    chk("wrap.g3", 64'(req_gnt), 64'b1000);
    req = 4'b0010;
    tick(); tick();
    tick();
    chk("wrap.g1b", 64'(req_gnt), 64'b0010);
    req = '0;
    tick(); tick();
    chk("wrap.rsp1", 64'(rsp_valid), 64'b0010);

    // Stuck completer on client 2 read.
    req[2] = 1'b1; req_write[2] = 1'b0; req_addr[2*AW +: AW] = 5'd3; pready = 1'b0; prdata = 32'h1234_5678;
    tick();
    chk("to.gnt", 64'(req_gnt), 64'b0100);
    req = '0;
`ifdef APB_ARB_TIMEOUT_EN
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk($sformatf("to.acc%0d", i), 64'({pselx, penable, rsp_valid}), 64'b110000);
    end
    tick();
    chk("to.psel_off", 64'({pselx, penable}), 64'd0);
    chk("to.rsp_valid", 64'(rsp_valid), 64'b0100);
    chk("to.err", 64'(rsp_err), 64'd1);
    chk("to.rdata0", 64'(rsp_rdata), 64'd0);
`else
    for (int i = 1; i <= 20; i++) begin
      tick();
      chk($sformatf("wait.acc%0d", i), 64'({pselx, penable, rsp_valid}), 64'b110000);
    end
    pready = 1'b1;
    tick();
    chk("wait.rsp_valid", 64'(rsp_valid), 64'b0100);
    chk("wait.err", 64'(rsp_err), 64'd0);
    chk("wait.rdata", 64'(rsp_rdata), 64'h1234_5678);
`endif
    pready = 1'b1;
    req[0] = 1'b1; req_write[0] = 1'b1; req_addr[0 +: AW] = 5'd9; req_wdata[0 +: DW] = 32'hCAFE_0001;
    tick();
    chk("after.gnt", 64'(req_gnt), 64'b0001);
    chk("after.paddr", 64'(paddr), 64'd9);
    req = '0;
    tick(); tick();
    chk("after.rsp", 64'(rsp_valid), 64'b0001);
    chk("after.err", 64'(rsp_err), 64'd0);

    // Reset during ACCESS drops the transfer and restarts arbitration at client 0.
    req[1] = 1'b1; req_write[1] = 1'b1; pready = 1'b0;
    tick();
    chk("mr.gnt", 64'(req_gnt), 64'b0010);
    req = '0;
    tick();
    chk("mr.access", 64'({pselx, penable}), 64'b11);
    prst_n = 1'b0;
    #1;
    chk_idle_out("mr.async");
    pready = 1'b1;
    tick();
    chk_idle_out("mr.held");
    prst_n = 1'b1;
    req = 4'b1111;
    tick();
    chk("mr.gnt0", 64'(req_gnt), 64'b0001);
    chk("mr.no_rsp", 64'(rsp_valid), 64'd0);
    req = '0;
    tick(); tick();
    chk("mr.rsp0", 64'(rsp_valid), 64'b0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
